// File: rtl/instr_sequencer.sv
// Instruction register, T0..T3 timestep sequencer and retire counter.
// Optional single-step fetch gating via SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Run,
  input  logic               Stall,
`ifdef SINGLE_STEP_EN
  input  logic               Step,
`endif
  input  logic [9:0]         ExtData,
  input  logic               ExtValid,
  output logic               ExtReady,
  input  logic               ResetTimestep,
  output logic [1:0]         CurrentTimestep,
  output logic [9:0]         Instruction,
  output logic [3:0]         Opcode,
  output logic [1:0]         Rx,
  output logic [1:0]         Ry,
  output logic [9:0]         ImmediateData,
  output logic               InstrDone,
  output logic               IllegalOp,
  output logic               SeqError,
  output logic [COUNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } ts_e;

  localparam logic [3:0] OP_LD = 4'b0000;

  ts_e                ts_q, ts_d;
  logic [9:0]         instr_q, instr_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               ill_q, ill_d;
  logic               retire;
  logic               is_ld;
  logic               fetch_en;
  logic               ready;

`ifdef SINGLE_STEP_EN
  logic arm_q, arm_d;
  logic fetch;
  assign fetch_en = arm_q;
`else
  assign fetch_en = 1'b1;
`endif

  assign is_ld = (instr_q[9:6] == OP_LD);

  // Ready depends only on registered state and level inputs, never ExtValid.
  always_comb begin
    ready = 1'b0;
    if (ResetN && !Stall) begin
      unique case (ts_q)
        T0:      ready = Run & fetch_en;
        T1:      ready = is_ld;
        default: ready = 1'b0;
      endcase
    end
  end

  assign ExtReady = ready;

  always_comb begin
    ts_d    = ts_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    retire  = 1'b0;
    if (!Stall) begin
      unique case (ts_q)
        T0: begin
          if (ready && ExtValid) begin
            instr_d = ExtData;
            if (ExtData[9:7] == 3'b111) ill_d = 1'b1;
            else                        ts_d  = T1;
          end
        end
        T1: begin
          if (is_ld) begin
            if (ExtValid) begin
              if (ResetTimestep) retire = 1'b1;
              else               ts_d   = T2;
            end
          end else if (ResetTimestep) begin
            retire = 1'b1;
          end else begin
            ts_d = T2;
          end
        end
        T2: begin
          if (ResetTimestep) retire = 1'b1;
          else               ts_d   = T3;
        end
        T3: begin
          retire = 1'b1;
          if (!ResetTimestep) err_d = 1'b1;
        end
        default: ts_d = T0;
      endcase
      if (retire) begin
        ts_d   = T0;
        done_d = 1'b1;
        if (cnt_q != {COUNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef SINGLE_STEP_EN
  assign fetch = (ts_q == T0) && ready && ExtValid;

  // A Step seen in the fetch cycle arms the following fetch.
  always_comb begin
    arm_d = arm_q;
    if (!Stall) begin
      if (fetch) arm_d = 1'b0;
      if (Step)  arm_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ts_q    <= T0;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef SINGLE_STEP_EN
      arm_q   <= 1'b1;
`endif
    end else begin
      ts_q    <= ts_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
`ifdef SINGLE_STEP_EN
      arm_q   <= arm_d;
`endif
    end
  end

  assign CurrentTimestep = ts_q;
  assign Instruction     = instr_q;
  assign Opcode          = instr_q[9:6];
  assign Rx              = instr_q[5:4];
  assign Ry              = instr_q[3:2];
  assign ImmediateData   = {6'b0, instr_q[3:0]};
  assign InstrDone       = done_q;
  assign IllegalOp       = ill_q;
  assign SeqError        = err_q;
  assign InstrCount      = cnt_q;

endmodule
